reindeer_mem_controller: RTL and testbench
==========================================

# reindeer_mem_controller

Single-port memory controller directly upstream of instruction fetch. Accepts single-cycle read pulses from the fetch stage and load/store pulses from the data path, arbitrates them onto one external memory bus (request/acknowledge) and returns a one-cycle `done` pulse with read data to the requester. Handles byte-lane generation for stores, lane selection and sign/zero extension for loads, and an acknowledge watchdog.

## Interface
- ACK_TIMEOUT, 255: cycles waited for `mem_ack` before aborting a transaction (1..255; counter is 8 bits).
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous reset; clears pending requests and FSM.
- fetch_read_enable  input  1  one-cycle fetch read request.
- fetch_read_addr  input  `PC_BITWIDTH`  fetch byte address; bits [1:0] ignored.
- fetch_read_done  output  1  one-cycle pulse, fetch data valid.
- fetch_read_data  output  `XLEN`  fetched word.
- data_read_enable  input  1  one-cycle load request.
- data_write_enable  input  1  one-cycle store request (write wins if both high).
- data_addr  input  `PC_BITWIDTH`  load/store byte address.
- data_width  input  2  0 byte, 1 half, 2/3 word.
- data_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
- data_write_data  input  `XLEN`  store data, right-aligned.
- data_done  output  1  one-cycle pulse, load/store complete.
- data_read_data  output  `XLEN`  aligned, extended load result.
- data_misaligned  output  1  pulse with `data_done` on rejected access.
- timeout_error  output  1  pulse with the aborted requester's `done`.
- mem_req  output  1  memory request, held until `mem_ack`.
- mem_we  output  1  1 = write.
- mem_addr  output  `PC_BITWIDTH`  word address, bits [1:0] = 0.
- mem_be  output  4  byte enables.
- mem_wdata  output  `XLEN`  lane-replicated write data.
- mem_rdata  input  `XLEN`  read data, valid in `mem_ack` cycle.
- mem_ack  input  1  one-cycle acknowledge.

## Operation
- Each port has a one-deep pending slot (address, width, unsigned, write data, we). A pulse loads the slot; a pulse while the slot is occupied and not yet issued overwrites it. An issued (in-flight) transaction always completes.
- FSM states: S_IDLE, S_WAIT. S_IDLE: if data request (incoming pulse or pending) -> issue data, else if fetch -> issue fetch, else stay. Data has priority on simultaneous requests; fetch stays pending.
- Issue: register mem_req=1, mem_addr, mem_we, mem_be, mem_wdata; go S_WAIT; clear timeout counter. Issue may consume a same-cycle incoming pulse directly.
- S_WAIT: hold bus outputs; on mem_ack drop mem_req, register owner's `done` and read data, return to S_IDLE. Counter increments each cycle without ack; on reaching ACK_TIMEOUT drop mem_req, pulse owner `done` with data 0 plus `timeout_error`.
- Fetch: mem_be=4'b1111, mem_we=0, data passed unmodified.
- Byte: mem_be = 1<<addr[1:0], wdata = byte x4; half: mem_be = addr[1] ? 4'b1100 : 4'b0011, wdata = half x2; word: 4'b1111.
- Loads: select lane by addr[1:0]/addr[1], extend to `XLEN` per data_unsigned; store `data_read_data` = 0.
- sync_reset: pending slots cleared, FSM to S_IDLE, mem_req low; a later mem_ack for the killed transaction is ignored (no done).

## Timing
- All outputs reset to 0 (async reset_n and sync_reset).
- Request pulse at cycle T with bus idle: mem_req high in T+1. mem_ack at cycle A (>= T+1): done pulse and data visible at A+1. Zero-wait minimum latency 2 cycles.
- New issue from S_IDLE at earliest the cycle after done is registered; back-to-back issue gap 1 cycle.
- fetch_read_data/data_read_data hold value until next done for that port.
- mem_ack outside S_WAIT ignored.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is not issued; data_done and data_misaligned pulse at T+1, data_read_data = 0, memory untouched.
- Undefined: no check; half uses addr[1] only, word ignores addr[1:0]; data_misaligned constant 0.

## Test plan
- Fetch pulse addr 0x0104, mem_ack one cycle after mem_req, rdata 0x00500093 -> mem_addr 0x0104, be 1111, fetch_read_done at T+2 with 0x00500093.
- Fetch and load byte signed addr 0x0203 same cycle, rdata 0x80000000 -> data issued first, data_read_data 0xFFFFFF80; fetch issued after, its done follows.
- Store half 0xBEEF to 0x0202 -> mem_we 1, mem_be 1100, mem_wdata 0xBEEFBEEF, data_done after ack.
- No ack, ACK_TIMEOUT=4 -> mem_req drops after 4 wait cycles, done + timeout_error pulse, data 0.
- With MEM_MISALIGN_CHECK_EN: load word 0x0101 -> no mem_req, data_done + data_misaligned at T+1.
- sync_reset during S_WAIT then late mem_ack -> no done pulse, outputs 0, next request served normally.

Source files
------------

// File: rtl/reindeer_mem_controller_if.sv
// reindeer_mem_controller_if: external single-port memory bus (request/acknowledge)
// Ports:
//   master - controller side: drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//            samples mem_rdata, mem_ack
//   slave  - memory side: the mirror image
`ifndef PC_BITWIDTH
`define PC_BITWIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface reindeer_mem_controller_if;
    logic                    mem_req;
    logic                    mem_we;
    logic [`PC_BITWIDTH-1:0] mem_addr;
    logic [3:0]              mem_be;
    logic [`XLEN-1:0]        mem_wdata;
    logic [`XLEN-1:0]        mem_rdata;
    logic                    mem_ack;

    modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/reindeer_mem_controller.sv
// reindeer_mem_controller: arbitrates fetch reads and data loads/stores onto one memory bus
// Ports:
//   clk, reset_n (async, active-low), i_sync_reset (sync clear of slots, FSM and outputs)
//   i_fetch_read_* / o_fetch_read_*  fetch port: request pulse, done pulse with word
//   i_data_* / o_data_*              load/store port: request pulse, done pulse with
//                                    extended load data, o_data_misaligned
//   o_timeout_error                  pulses with the aborted requester's done
//   mem                              memory bus (master modport)
// Parameter ACK_TIMEOUT (1..255): wait cycles without mem_ack before aborting.
// Build option MEM_MISALIGN_CHECK_EN: reject misaligned half/word accesses without a bus cycle.
`ifndef PC_BITWIDTH
`define PC_BITWIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module reindeer_mem_controller #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_sync_reset,
    input  logic                    i_fetch_read_enable,
    input  logic [`PC_BITWIDTH-1:0] i_fetch_read_addr,
    output logic                    o_fetch_read_done,
    output logic [`XLEN-1:0]        o_fetch_read_data,
    input  logic                    i_data_read_enable,
    input  logic                    i_data_write_enable,
    input  logic [`PC_BITWIDTH-1:0] i_data_addr,
    input  logic [1:0]              i_data_width,
    input  logic                    i_data_unsigned,
    input  logic [`XLEN-1:0]        i_data_write_data,
    output logic                    o_data_done,
    output logic [`XLEN-1:0]        o_data_read_data,
    output logic                    o_data_misaligned,
    output logic                    o_timeout_error,
    reindeer_mem_controller_if.master mem
);
    localparam int PW = `PC_BITWIDTH;
    localparam int XW = `XLEN;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t r_state, w_state_nxt;

    logic          r_f_pend, r_d_pend, r_d_uns, r_d_we, r_own_d, r_own_uns;
    logic [PW-1:0] r_f_addr, r_d_addr;
    logic [1:0]    r_d_width, r_own_width, r_own_lane;
    logic [XW-1:0] r_d_wdata;
    logic [7:0]    r_cnt;

    // A same-cycle pulse takes precedence over (overwrites) the pending slot.
    logic          w_d_pulse, w_d_req, w_f_req, w_d_uns, w_d_we, w_mis;
    logic [PW-1:0] w_d_addr, w_f_addr;
    logic [1:0]    w_d_width;
    logic [XW-1:0] w_d_wdata, w_wdata, w_load;
    logic [3:0]    w_be;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_issue_d, w_issue_f, w_reject, w_ack, w_abort;

    assign w_d_pulse = i_data_read_enable | i_data_write_enable;
    assign w_d_req   = w_d_pulse | r_d_pend;
    assign w_f_req   = i_fetch_read_enable | r_f_pend;
    assign w_d_addr  = w_d_pulse ? i_data_addr : r_d_addr;
    assign w_d_width = w_d_pulse ? i_data_width : r_d_width;
    assign w_d_uns   = w_d_pulse ? i_data_unsigned : r_d_uns;
    assign w_d_wdata = w_d_pulse ? i_data_write_data : r_d_wdata;
    assign w_d_we    = w_d_pulse ? i_data_write_enable : r_d_we;
    assign w_f_addr  = i_fetch_read_enable ? i_fetch_read_addr : r_f_addr;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = (w_d_width == 2'd1 && w_d_addr[0]) || (w_d_width[1] && w_d_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_be    = w_d_width == 2'd0 ? 4'b0001 << w_d_addr[1:0] :
                     w_d_width == 2'd1 ? (w_d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_d_width == 2'd0 ? {4{w_d_wdata[7:0]}} :
                     w_d_width == 2'd1 ? {2{w_d_wdata[15:0]}} : w_d_wdata;

    assign w_byte = mem.mem_rdata[{r_own_lane, 3'b000} +: 8];
    assign w_half = r_own_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    assign w_load = r_own_width == 2'd0 ? {{(XW-8){~r_own_uns & w_byte[7]}}, w_byte} :
                    r_own_width == 2'd1 ? {{(XW-16){~r_own_uns & w_half[15]}}, w_half} : mem.mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else if (i_sync_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_d   = 1'b0;
        w_issue_f   = 1'b0;
        w_reject    = 1'b0;
        w_ack       = 1'b0;
        w_abort     = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_d_req && w_mis)
                w_reject = 1'b1;
            else if (w_d_req) begin
                w_issue_d   = 1'b1;
                w_state_nxt = S_WAIT;
            end else if (w_f_req) begin
                w_issue_f   = 1'b1;
                w_state_nxt = S_WAIT;
            end
        end else if (mem.mem_ack) begin
            w_ack       = 1'b1;
            w_state_nxt = S_IDLE;
        end else if (r_cnt == 8'(ACK_TIMEOUT - 1)) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_f_pend, r_d_pend, r_d_uns, r_d_we, r_own_d, r_own_uns} <= '0;
            {r_f_addr, r_d_addr, r_d_width, r_own_width, r_own_lane, r_d_wdata, r_cnt} <= '0;
            {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata} <= '0;
            {o_fetch_read_done, o_fetch_read_data, o_data_done, o_data_read_data} <= '0;
            {o_data_misaligned, o_timeout_error} <= '0;
        end else if (i_sync_reset) begin
            {r_f_pend, r_d_pend, r_d_uns, r_d_we, r_own_d, r_own_uns} <= '0;
            {r_f_addr, r_d_addr, r_d_width, r_own_width, r_own_lane, r_d_wdata, r_cnt} <= '0;
            {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata} <= '0;
            {o_fetch_read_done, o_fetch_read_data, o_data_done, o_data_read_data} <= '0;
            {o_data_misaligned, o_timeout_error} <= '0;
        end else begin
            o_fetch_read_done <= 1'b0;
            o_data_done       <= 1'b0;
            o_data_misaligned <= 1'b0;
            o_timeout_error   <= 1'b0;
            if (w_issue_f)
                r_f_pend <= 1'b0;
            else if (i_fetch_read_enable) begin
                r_f_pend <= 1'b1;
                r_f_addr <= i_fetch_read_addr;
            end
            if (w_issue_d || w_reject)
                r_d_pend <= 1'b0;
            else if (w_d_pulse) begin
                r_d_pend  <= 1'b1;
                r_d_addr  <= i_data_addr;
                r_d_width <= i_data_width;
                r_d_uns   <= i_data_unsigned;
                r_d_wdata <= i_data_write_data;
                r_d_we    <= i_data_write_enable;
            end
            if (w_issue_d || w_issue_f) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= w_issue_d & w_d_we;
                mem.mem_addr  <= (w_issue_d ? w_d_addr : w_f_addr) & ~PW'(3);
                mem.mem_be    <= w_issue_d ? w_be : 4'b1111;
                mem.mem_wdata <= w_issue_d ? w_wdata : '0;
                r_cnt         <= '0;
                r_own_d       <= w_issue_d;
                r_own_lane    <= w_d_addr[1:0];
                r_own_width   <= w_d_width;
                r_own_uns     <= w_d_uns;
            end
            if (r_state == S_WAIT && !w_ack && !w_abort)
                r_cnt <= r_cnt + 8'd1;
            if (w_ack || w_abort) begin
                mem.mem_req     <= 1'b0;
                o_timeout_error <= w_abort;
                if (r_own_d) begin
                    o_data_done      <= 1'b1;
                    o_data_read_data <= (w_abort || mem.mem_we) ? '0 : w_load;
                end else begin
                    o_fetch_read_done <= 1'b1;
                    o_fetch_read_data <= w_abort ? '0 : mem.mem_rdata;
                end
            end
            if (w_reject) begin
                o_data_done       <= 1'b1;
                o_data_misaligned <= 1'b1;
                o_data_read_data  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reindeer_mem_controller.sv
// tb_reindeer_mem_controller: directed self-checking bench for reindeer_mem_controller
module tb_reindeer_mem_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        f_en = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_done;
    logic [31:0] f_data;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_width = '0;
    logic        d_uns = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_mis;
    logic        t_err;
    int          n_cmp = 0;
    int          n_err = 0;

    reindeer_mem_controller_if mif();

    reindeer_mem_controller #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .i_sync_reset(sync_reset),
        .i_fetch_read_enable(f_en), .i_fetch_read_addr(f_addr),
        .o_fetch_read_done(f_done), .o_fetch_read_data(f_data),
        .i_data_read_enable(d_re), .i_data_write_enable(d_we), .i_data_addr(d_addr),
        .i_data_width(d_width), .i_data_unsigned(d_uns), .i_data_write_data(d_wdata),
        .o_data_done(d_done), .o_data_read_data(d_rdata), .o_data_misaligned(d_mis),
        .o_timeout_error(t_err), .mem(mif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ack(input logic [31:0] rd);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rd;
        step();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
    endtask

    task automatic data_pulse(input logic we, input logic [31:0] a, input logic [1:0] w, input logic u, input logic [31:0] wd);
        d_re = ~we; d_we = we; d_addr = a; d_width = w; d_uns = u; d_wdata = wd;
        step();
        d_re = 1'b0; d_we = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mif.mem_req && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(mif.mem_req), 32'd1);
    endtask

    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        step();
        step();
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        chk("rst_outs", {26'd0, f_done, d_done, d_mis, t_err, mif.mem_we, 1'b0}, 32'd0);
        chk("rst_fdata", f_data, 32'd0);
        reset_n = 1'b1;
        step();

        // fetch, zero-wait ack
        f_en = 1'b1; f_addr = 32'h0000_0104;
        step();
        f_en = 1'b0;
        chk("f_req", 32'(mif.mem_req), 32'd1);
        chk("f_addr", mif.mem_addr, 32'h0000_0104);
        chk("f_be", 32'(mif.mem_be), 32'hF);
        chk("f_we", 32'(mif.mem_we), 32'd0);
        ack(32'h0050_0093);
        chk("f_done", 32'(f_done), 32'd1);
        chk("f_data", f_data, 32'h0050_0093);
        step();
        chk("f_done_pulse", 32'(f_done), 32'd0);
        chk("f_data_hold", f_data, 32'h0050_0093);

        // simultaneous fetch and signed byte load: data wins
        f_en = 1'b1; f_addr = 32'h0000_0300;
        data_pulse(1'b0, 32'h0000_0203, 2'd0, 1'b0, 32'd0);
        f_en = 1'b0;
        chk("lb_addr", mif.mem_addr, 32'h0000_0200);
        chk("lb_be", 32'(mif.mem_be), 32'h8);
        ack(32'h8000_0000);
        chk("lb_done", 32'(d_done), 32'd1);
        chk("lb_data", d_rdata, 32'hFFFF_FF80);
        chk("lb_fdone", 32'(f_done), 32'd0);
        chk("lb_gap_req", 32'(mif.mem_req), 32'd0);
        step();
        chk("pf_req", 32'(mif.mem_req), 32'd1);
        chk("pf_addr", mif.mem_addr, 32'h0000_0300);
        ack(32'h1234_5678);
        chk("pf_done", 32'(f_done), 32'd1);
        chk("pf_data", f_data, 32'h1234_5678);
        chk("lb_hold", d_rdata, 32'hFFFF_FF80);
        step();

        // store half, one wait cycle
        data_pulse(1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'h0000_BEEF);
        chk("sh_we", 32'(mif.mem_we), 32'd1);
        chk("sh_be", 32'(mif.mem_be), 32'hC);
        chk("sh_wdata", mif.mem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", mif.mem_addr, 32'h0000_0200);
        step();
        chk("sh_hold", {31'd0, mif.mem_req} & {32{mif.mem_wdata == 32'hBEEF_BEEF}}, 32'd1);
        ack(32'hFFFF_FFFF);
        chk("sh_done", 32'(d_done), 32'd1);
        chk("sh_data", d_rdata, 32'd0);
        step();

        // store byte at lane 1
        data_pulse(1'b1, 32'h0000_0101, 2'd0, 1'b0, 32'h0000_00A5);
        chk("sb_be", 32'(mif.mem_be), 32'h2);
        chk("sb_wdata", mif.mem_wdata, 32'hA5A5_A5A5);
        ack(32'd0);
        step();

        // unsigned half load from upper lane
        data_pulse(1'b0, 32'h0000_0206, 2'd1, 1'b1, 32'd0);
        chk("lhu_be", 32'(mif.mem_be), 32'hC);
        ack(32'h8001_7FFF);
        chk("lhu_data", d_rdata, 32'h0000_8001);
        step();

        // signed half load from lower lane
        data_pulse(1'b0, 32'h0000_0204, 2'd1, 1'b0, 32'd0);
        ack(32'h0000_8002);
        chk("lh_data", d_rdata, 32'hFFFF_8002);
        step();

        // ack timeout
        data_pulse(1'b0, 32'h0000_0400, 2'd2, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), 32'(mif.mem_req), 32'd1);
            chk($sformatf("to_nodone%0d", i), 32'(d_done), 32'd0);
            step();
        end
        chk("to_req_drop", 32'(mif.mem_req), 32'd0);
        chk("to_done", 32'(d_done), 32'd1);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_data", d_rdata, 32'd0);
        step();
        chk("to_err_pulse", 32'(t_err), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        data_pulse(1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'd0);
        chk("mis_req", 32'(mif.mem_req), 32'd0);
        chk("mis_done", 32'(d_done), 32'd1);
        chk("mis_flag", 32'(d_mis), 32'd1);
        chk("mis_data", d_rdata, 32'd0);
        step();
`else
        data_pulse(1'b1, 32'h0000_0203, 2'd1, 1'b0, 32'h0000_1234);
        chk("nomis_be", 32'(mif.mem_be), 32'hC);
        chk("nomis_wdata", mif.mem_wdata, 32'h1234_1234);
        ack(32'd0);
        chk("nomis_flag", 32'(d_mis), 32'd0);
        chk("nomis_done", 32'(d_done), 32'd1);
        step();
`endif

        // sync reset during wait, then a stray late ack
        f_en = 1'b1; f_addr = 32'h0000_0500;
        step();
        f_en = 1'b0;
        chk("sr_req", 32'(mif.mem_req), 32'd1);
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        chk("sr_req_low", 32'(mif.mem_req), 32'd0);
        chk("sr_fdata", f_data, 32'd0);
        chk("sr_addr", mif.mem_addr, 32'd0);
        ack(32'hDEAD_BEEF);
        chk("sr_late_f", 32'(f_done), 32'd0);
        chk("sr_late_d", 32'(d_done), 32'd0);
        chk("sr_late_fdata", f_data, 32'd0);
        f_en = 1'b1; f_addr = 32'h0000_0600;
        step();
        f_en = 1'b0;
        wait_req("sr_next_req");
        chk("sr_next_addr", mif.mem_addr, 32'h0000_0600);
        ack(32'hCAFE_0001);
        chk("sr_next_done", 32'(f_done), 32'd1);
        chk("sr_next_data", f_data, 32'hCAFE_0001);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
